// File: rtl/pueo_metabeam_trigger.sv
// Runtime-programmable metabeam trigger.
// Per-beam threshold bits are masked, OR-reduced into metabeam hits through a
// writable beam-index table, gated by a per-metabeam holdoff, and presented on
// a valid/ready output that merges new fires into a stalled word.
// Pipeline: masked beams (stage 1) -> metabeam hits (stage 2) -> output register.
module pueo_metabeam_trigger #(
  parameter int NUM_BEAM   = 48,
  parameter int NUM_META   = 8,
  parameter int META_SLOTS = 22,
  parameter int IDX_BITS   = 8,
  parameter int HOLD_BITS  = 8,
  localparam int MW = (NUM_META   > 1) ? $clog2(NUM_META)   : 1,
  localparam int SW = (META_SLOTS > 1) ? $clog2(META_SLOTS) : 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_BEAM-1:0]  beam_trig_i,
  input  logic [NUM_BEAM-1:0]  beam_mask_i,
  input  logic [NUM_META-1:0]  meta_en_i,
  input  logic [HOLD_BITS-1:0] holdoff_i,
  input  logic                 tbl_wr_i,
  input  logic [MW-1:0]        tbl_meta_i,
  input  logic [SW-1:0]        tbl_slot_i,
  input  logic [IDX_BITS-1:0]  tbl_idx_i,
  output logic                 trig_valid_o,
  output logic [NUM_META-1:0]  trig_meta_o,
  input  logic                 trig_ready_i,
  output logic                 ovf_o,
  input  logic                 ovf_clr_i
);

  // Masked beams are zero-extended to the full index range so that any entry
  // >= NUM_BEAM (including the all-ones "unused" marker) selects a constant 0.
  localparam int EXT = 1 << IDX_BITS;

  logic [IDX_BITS-1:0]  tbl_q   [NUM_META][META_SLOTS];
  logic [NUM_BEAM-1:0]  masked_q;
  logic [EXT-1:0]       masked_ext;
  logic [NUM_META-1:0]  hit_d, hit_q;
  logic [HOLD_BITS-1:0] hold_q  [NUM_META];
  logic [HOLD_BITS-1:0] hold_d  [NUM_META];
  logic [NUM_META-1:0]  fire;
  logic                 accept;
  logic                 valid_d, valid_q;
  logic [NUM_META-1:0]  meta_d, meta_q;
  logic                 ovf_d, ovf_q;

  assign masked_ext = {{(EXT-NUM_BEAM){1'b0}}, masked_q};

  // Index table: entries reset to all-ones; out-of-range selects match no entry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int m = 0; m < NUM_META; m++)
        for (int s = 0; s < META_SLOTS; s++)
          tbl_q[m][s] <= '1;
    end else if (tbl_wr_i) begin
      for (int m = 0; m < NUM_META; m++)
        for (int s = 0; s < META_SLOTS; s++)
          if (tbl_meta_i == MW'(m) && tbl_slot_i == SW'(s))
            tbl_q[m][s] <= tbl_idx_i;
    end
  end

  // Metabeam hit: OR of the table-selected masked beams, gated by enable.
  always_comb begin
    hit_d = '0;
    for (int m = 0; m < NUM_META; m++)
      for (int s = 0; s < META_SLOTS; s++)
        hit_d[m] = hit_d[m] | masked_ext[tbl_q[m][s]];
    hit_d = hit_d & meta_en_i;
  end

  // Stage 1 and stage 2 pipeline registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      masked_q <= '0;
      hit_q    <= '0;
    end else begin
      masked_q <= beam_trig_i & ~beam_mask_i;
      hit_q    <= hit_d;
    end
  end

  // Fire decision, holdoff reload/decrement and output coalescing.
  always_comb begin
    for (int m = 0; m < NUM_META; m++) begin
      fire[m] = hit_q[m] & (hold_q[m] == '0);
      if (fire[m])
        hold_d[m] = holdoff_i;
      else if (hold_q[m] != '0)
        hold_d[m] = hold_q[m] - HOLD_BITS'(1);
      else
        hold_d[m] = '0;
    end

    accept = !valid_q || trig_ready_i;
    if (accept) begin
      meta_d  = fire;
      valid_d = |fire;
    end else begin
      meta_d  = meta_q | fire;
      valid_d = 1'b1;
    end

    // Set is evaluated last so it wins over a simultaneous clear.
    ovf_d = ovf_q;
    if (ovf_clr_i)
      ovf_d = 1'b0;
    if (!accept && |(fire & meta_q))
      ovf_d = 1'b1;
  end

  // Holdoff counters run independently of the output handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int m = 0; m < NUM_META; m++)
        hold_q[m] <= '0;
    end else begin
      for (int m = 0; m < NUM_META; m++)
        hold_q[m] <= hold_d[m];
    end
  end

  // Output register and sticky overflow flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      meta_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      meta_q  <= meta_d;
      ovf_q   <= ovf_d;
    end
  end

  assign trig_valid_o = valid_q;
  assign trig_meta_o  = meta_q;
  assign ovf_o        = ovf_q;

endmodule
